// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin burst arbiter steering one 4:1 mux output path.
//            A grant is held until a last beat or the beat cap, then the
//            next requester in rotation is considered after one idle cycle.
// Options  : `define ARB_WATCHDOG_EN to release a grant whose requester
//            stays idle for TIMEOUT consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic [3:0]           in_last,
    output logic [3:0]           in_ready,
    output logic [3:0]           gnt,
    output logic [1:0]           sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Beat index at which the burst is forcibly terminated
    localparam logic [7:0] C_CAP = 8'(MAX_BURST - 1);

    // Elaboration-time sanity checks on parameter ranges
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("mux4_rr_arbiter: MAX_BURST must be in 1..255");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mux4_rr_arbiter: TIMEOUT must be at least 1");
    end

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_gnt, w_gnt_nxt;
    logic [1:0]  r_sel, w_sel_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic [7:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [1:0]  w_win;
    logic        w_busy;
    logic        w_beat;
    logic        w_burst_end;
    logic        w_wd_fire;

    assign w_busy = (r_state == ST_BUSY);

    // Datapath is purely combinational from the registered select
    assign out_valid   = w_busy & req[r_sel];
    assign out_last    = w_busy & (in_last[r_sel] | (r_beat_cnt == C_CAP));
    assign in_ready    = w_busy ? (r_gnt & {4{out_ready}}) : 4'b0000;
    assign out_data    = in_data[int'(r_sel) * WIDTH +: WIDTH];
    assign gnt         = r_gnt;
    assign sel         = r_sel;
    assign w_beat      = out_valid & out_ready;
    assign w_burst_end = w_beat & out_last;

    // Rotating priority: scan ptr+1, ptr+2, ptr+3, ptr; lowest offset wins
    always_comb begin
        w_win = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int                C_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);

    logic [C_WD_W-1:0] r_idle_cnt;

    // Fires on the edge where the idle count would reach TIMEOUT
    assign w_wd_fire = w_busy & ~req[r_sel] & (r_idle_cnt == C_WD_LAST);

    // Count consecutive BUSY cycles in which the grant holder is not requesting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_busy || req[r_sel] || w_wd_fire) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_wd_fire = 1'b0;
`endif

    // Next-state and grant bookkeeping
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt    = ST_BUSY;
                    w_gnt_nxt      = 4'b0001 << w_win;
                    w_sel_nxt      = w_win;
                    w_beat_cnt_nxt = 8'd0;
                end
            end
            ST_BUSY: begin
                if (w_burst_end || w_wd_fire) begin
                    // sel is left alone so out_data keeps pointing at the last owner
                    w_state_nxt    = ST_IDLE;
                    w_gnt_nxt      = 4'b0000;
                    w_ptr_nxt      = r_sel;
                    w_beat_cnt_nxt = 8'd0;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; ptr resets to 3 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'b00;
            r_ptr      <= 2'b11;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Self-checking bench for mux4_rr_arbiter: directed scenarios plus
//            randomized traffic compared against a behavioural model.
//            Honours `define ARB_WATCHDOG_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 8;
    localparam int TIMEOUT   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [3:0]           req = '0;
    logic [4*WIDTH-1:0]   in_data = '0;
    logic [3:0]           in_last = '0;
    logic                 out_ready = 1'b0;
    logic [3:0]           in_ready;
    logic [3:0]           gnt;
    logic [1:0]           sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Behavioural reference: owner index, rotation pointer, beats so far
    int m_busy  = 0;
    int m_sel   = 0;
    int m_ptr   = 3;
    int m_beats = 0;
    int m_idle  = 0;

    // Model advances on each rising edge from the same inputs the DUT sees
    always @(posedge clk) begin : ref_model
        int win;
        bit beat;
        bit last;
        if (rst) begin
            m_busy <= 0; m_sel <= 0; m_ptr <= 3; m_beats <= 0; m_idle <= 0;
        end else if (m_busy == 0) begin
            if (req != 4'b0000) begin
                win = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
                end
                m_busy <= 1; m_sel <= win; m_beats <= 0; m_idle <= 0;
            end
        end else begin
            beat = req[m_sel] && out_ready;
            last = in_last[m_sel] || (m_beats == MAX_BURST - 1);
            if (beat && last) begin
                m_busy <= 0; m_ptr <= m_sel; m_beats <= 0; m_idle <= 0;
            end else begin
                if (beat) m_beats <= m_beats + 1;
`ifdef ARB_WATCHDOG_EN
                if (req[m_sel]) begin
                    m_idle <= 0;
                end else if (m_idle + 1 == TIMEOUT) begin
                    m_busy <= 0; m_ptr <= m_sel; m_beats <= 0; m_idle <= 0;
                end else begin
                    m_idle <= m_idle + 1;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; in_last = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_data = 32'h44332211;
        rst = 1'b1; req = '0; in_last = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, sel, out_valid, out_last, in_ready} !== 12'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {gnt, sel, out_valid, out_last, in_ready}, 12'b0);
        end
        checks++;
        if (out_data !== 8'h11) begin
            failures++;
            $display("FAIL reset_data got=%h exp=11", out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        do_reset();
        req = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_s = 2'(k % 4);
            exp_g = 4'b0001 << exp_s;
            tick(); @(negedge clk);
            checks++;
            if ({gnt, sel, out_valid, out_last, in_ready} !== {exp_g, exp_s, 1'b1, 1'b1, exp_g}) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k,
                         {gnt, sel, out_valid, out_last, in_ready}, {exp_g, exp_s, 1'b1, 1'b1, exp_g});
            end
            tick(); @(negedge clk);
            checks++;
            if (gnt !== 4'b0000) begin
                failures++;
                $display("FAIL rr_bubble k=%0d got=%b exp=0000", k, gnt);
            end
        end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        in_data = '0; in_data[2*WIDTH +: WIDTH] = 8'hA5;
        in_last = 4'b0100; req = 4'b0100; out_ready = 1'b1;
        tick(); @(negedge clk);
        checks++;
        if ({gnt, sel, out_valid, out_last, in_ready, out_data} !== {4'b0100, 2'b10, 1'b1, 1'b1, 4'b0100, 8'hA5}) begin
            failures++;
            $display("FAIL single_grant got=%b exp=%b", {gnt, sel, out_valid, out_last, in_ready, out_data},
                     {4'b0100, 2'b10, 1'b1, 1'b1, 4'b0100, 8'hA5});
        end
        tick(); req = '0; @(negedge clk);
        checks++;
        if ({gnt, sel, out_valid} !== {4'b0000, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL single_release got=%b exp=%b", {gnt, sel, out_valid}, {4'b0000, 2'b10, 1'b0});
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        in_data = '0; in_last = '0; req = 4'b0010; out_ready = 1'b1;
        in_data[WIDTH +: WIDTH] = 8'h01;
        tick();
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk);
            checks++;
            if ({gnt, out_valid, out_data, out_last} !== {4'b0010, 1'b1, 8'(b), (b == 8)}) begin
                failures++;
                $display("FAIL cap_beat b=%0d got=%b exp=%b", b, {gnt, out_valid, out_data, out_last},
                         {4'b0010, 1'b1, 8'(b), (b == 8)});
            end
            tick();
            in_data[WIDTH +: WIDTH] = 8'(b + 1);
        end
        @(negedge clk);
        checks++;
        if ({gnt, out_valid} !== 5'b00000) begin
            failures++;
            $display("FAIL cap_release got=%b exp=00000", {gnt, out_valid});
        end
        tick(); @(negedge clk);
        checks++;
        if ({gnt, out_data} !== {4'b0010, 8'h09}) begin
            failures++;
            $display("FAIL cap_regrant got=%b exp=%b", {gnt, out_data}, {4'b0010, 8'h09});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data = '0; in_last = '0; req = 4'b0001; out_ready = 1'b1;
        in_data[WIDTH-1:0] = 8'h10;
        tick();
        tick(); in_data[WIDTH-1:0] = 8'h11;
        tick(); in_data[WIDTH-1:0] = 8'h12;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt, in_ready, out_valid, out_last, out_data} !== {4'b0001, 4'b0000, 1'b1, 1'b0, 8'h12}) begin
                failures++;
                $display("FAIL bp_stall i=%0d got=%b exp=%b", i, {gnt, in_ready, out_valid, out_last, out_data},
                         {4'b0001, 4'b0000, 1'b1, 1'b0, 8'h12});
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_data, out_last} !== {4'b0001, 8'(8'h12 + i), (i == 5)}) begin
                failures++;
                $display("FAIL bp_resume i=%0d got=%b exp=%b", i, {in_ready, out_data, out_last},
                         {4'b0001, 8'(8'h12 + i), (i == 5)});
            end
            tick();
            in_data[WIDTH-1:0] = 8'(8'h13 + i);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL bp_release got=%b exp=0000", gnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in_data = '0; in_last = '0; req = 4'b0100; out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1; req = 4'hF;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, in_ready, sel} !== 11'b0) begin
            failures++;
            $display("FAIL rstmid_clear got=%b exp=%b", {gnt, out_valid, in_ready, sel}, 11'b0);
        end
        tick(); @(negedge clk);
        checks++;
        if ({gnt, sel} !== {4'b0001, 2'b00}) begin
            failures++;
            $display("FAIL rstmid_regrant got=%b exp=000100", {gnt, sel});
        end
    endtask

    task automatic test_idle_holder();
        do_reset();
        in_data = '0; in_last = '0; req = 4'b1000; out_ready = 1'b1;
        tick(); @(negedge clk);
        checks++;
        if ({gnt, sel} !== {4'b1000, 2'b11}) begin
            failures++;
            $display("FAIL idle_grant got=%b exp=100011", {gnt, sel});
        end
        req = 4'b0001;
`ifdef ARB_WATCHDOG_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            tick(); @(negedge clk);
            checks++;
            if ({gnt, out_valid} !== {4'b1000, 1'b0}) begin
                failures++;
                $display("FAIL wd_hold i=%0d got=%b exp=10000", i, {gnt, out_valid});
            end
        end
        tick(); @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL wd_release got=%b exp=0000", gnt);
        end
        tick(); @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wd_next got=%b exp=0001", gnt);
        end
`else
        for (int i = 0; i < 110; i++) begin
            tick(); @(negedge clk);
            checks++;
            if ({gnt, out_valid, in_ready} !== {4'b1000, 1'b0, 4'b1000}) begin
                failures++;
                $display("FAIL hold i=%0d got=%b exp=100001000", i, {gnt, out_valid, in_ready});
            end
        end
`endif
        req = '0;
    endtask

    task automatic test_random();
        logic [3:0]       exp_g;
        logic [3:0]       exp_r;
        logic             exp_v;
        logic             exp_l;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                req[i]     = ($urandom_range(0, 9) < 7);
                in_last[i] = ($urandom_range(0, 9) < 3);
                in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
            end
            @(negedge clk);
            exp_g = (m_busy != 0) ? 4'(1 << m_sel) : 4'b0000;
            exp_v = (m_busy != 0) && req[m_sel];
            exp_l = (m_busy != 0) && (in_last[m_sel] || (m_beats == MAX_BURST - 1));
            exp_r = out_ready ? exp_g : 4'b0000;
            exp_d = in_data[m_sel*WIDTH +: WIDTH];
            checks++;
            if ({gnt, sel, out_valid, out_last, in_ready, out_data} !== {exp_g, 2'(m_sel), exp_v, exp_l, exp_r, exp_d}) begin
                failures++;
                $display("FAIL rand n=%0d got=%b exp=%b", n, {gnt, sel, out_valid, out_last, in_ready, out_data},
                         {exp_g, 2'(m_sel), exp_v, exp_l, exp_r, exp_d});
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_burst_cap();
        test_backpressure();
        test_reset_mid_burst();
        test_idle_holder();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
`default_nettype wire
